// File: rtl/imm_ext_pipe.sv
// Immediate extraction queue.
// Each accepted instruction word is decoded into its immediate class and
// extended immediate at push time. The decoded result and the original word
// are then held in a small circular FIFO until the consumer takes them.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_type,
  output logic                     out_illegal,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  // Every class builds a 32-bit immediate whose bit 31 already carries the
  // class sign bit, so widening to XLEN is a plain signed extension.
  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [4:0]              w_op_p0;
  logic signed [31:0]      w_imm32_p0;
  logic signed [XLEN-1:0]  w_imm_p0;
  logic [2:0]              w_type_p0;
  logic                    w_ill_p0;

  logic                    w_push;
  logic                    w_pop;

  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [CW-1:0]           r_count;

  logic signed [XLEN-1:0]  r_imm_mem  [DEPTH];
  logic [2:0]              r_type_mem [DEPTH];
  logic                    r_ill_mem  [DEPTH];
  logic [31:0]             r_inst_mem [DEPTH];

  assign w_op_p0 = in_inst[6:2];

  // Stage p0: classify the incoming word and assemble its 32-bit immediate.
  always_comb begin
    w_type_p0  = T_NONE;
    w_ill_p0   = 1'b1;
    w_imm32_p0 = '0;
    if (in_inst[1:0] == 2'b11) begin
      case (w_op_p0)
        5'b00100, 5'b00000, 5'b11001: begin
          w_ill_p0   = 1'b0;
          w_type_p0  = T_I;
          w_imm32_p0 = {{20{in_inst[31]}}, in_inst[31:20]};
        end
        5'b00110: begin
          if (XLEN == 64) begin
            w_ill_p0   = 1'b0;
            w_type_p0  = T_I;
            w_imm32_p0 = {{20{in_inst[31]}}, in_inst[31:20]};
          end
        end
        5'b01000: begin
          w_ill_p0   = 1'b0;
          w_type_p0  = T_S;
          w_imm32_p0 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        end
        5'b11000: begin
          w_ill_p0   = 1'b0;
          w_type_p0  = T_B;
          w_imm32_p0 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                        in_inst[30:25], in_inst[11:8], 1'b0};
        end
        5'b00101, 5'b01101: begin
          w_ill_p0   = 1'b0;
          w_type_p0  = T_U;
          w_imm32_p0 = {in_inst[31:12], 12'b0};
        end
        5'b11011: begin
          w_ill_p0   = 1'b0;
          w_type_p0  = T_J;
          w_imm32_p0 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                        in_inst[20], in_inst[30:21], 1'b0};
        end
        5'b11100: begin
          // SYSTEM: only the register-free CSR forms carry a zimm.
          w_ill_p0 = 1'b0;
          if (in_inst[14]) begin
            w_type_p0  = T_Z;
            w_imm32_p0 = {27'b0, in_inst[19:15]};
          end
        end
        5'b01100, 5'b00011: begin
          w_ill_p0 = 1'b0;
        end
        5'b01110: begin
          if (XLEN == 64) w_ill_p0 = 1'b0;
        end
        default: begin
          w_ill_p0 = 1'b1;
        end
      endcase
    end
  end

  assign w_imm_p0 = sext32(w_imm32_p0);

  // Handshake decisions come from registered occupancy only, so in_ready
  // never depends on out_ready within the same cycle.
  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Stage p1 storage: decoded results land in the entry at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_imm_mem[r_wptr]  <= w_imm_p0;
      r_type_mem[r_wptr] <= w_type_p0;
      r_ill_mem[r_wptr]  <= w_ill_p0;
      r_inst_mem[r_wptr] <= in_inst;
    end
  end

  // Pointer and occupancy control; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation: data reads as zero whenever the queue is empty.
  always_comb begin
    out_imm     = '0;
    out_type    = T_NONE;
    out_illegal = 1'b0;
    out_inst    = '0;
    if (out_valid) begin
      out_imm     = r_imm_mem[r_rptr];
      out_type    = r_type_mem[r_rptr];
      out_illegal = r_ill_mem[r_rptr];
      out_inst    = r_inst_mem[r_rptr];
    end
  end

endmodule
